// File: rtl/note_lane_shifter_pkg.sv
// Shared definitions for the falling-note lane: note codes, controller states and judge window size.
package note_lane_shifter_pkg;

    localparam logic [1:0] NOTE_NONE = 2'b00;
    localparam logic [1:0] NOTE_RED  = 2'b01;
    localparam logic [1:0] NOTE_BLUE = 2'b10;

    // Must agree with the button judge's decoding of the 3-bit offset.
    localparam int JUDGE_WIN = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/note_lane_shifter_step_timer.sv
// Scroll period timer: counts 0..STEP_CYCLES-1 while enabled, ticks on the last count, held at 0 when disabled.
module step_timer #(
    parameter int STEP_CYCLES = 2500000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int CW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // register samples the pre-edge values of the others regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/note_lane_shifter.sv
// Falling-note lane: scrolls red/blue notes toward the hit line, reports the head note, handles deletes.
// Optional build macro NOTE_LANE_MISS_CNT_EN adds a saturating miss_count output.
module note_lane_shifter
    import note_lane_shifter_pkg::*;
#(
    parameter int LANE_LEN    = 16,
    parameter int STEP_CYCLES = 2500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                chart_valid,
    input  logic [1:0]          chart_note,
    input  logic                chart_last,
    output logic                chart_ready,
    input  logic                delete_red_node,
    input  logic                delete_blue_node,
    output logic                node_R,
    output logic                node_B,
    output logic [2:0]          offset,
    output logic                miss,
    output logic                done,
    output logic [LANE_LEN-1:0] lane_r,
    output logic [LANE_LEN-1:0] lane_b
`ifdef NOTE_LANE_MISS_CNT_EN
    ,
    output logic [7:0]          miss_count
`endif
);

    localparam int WIN_BASE = LANE_LEN - JUDGE_WIN;
    localparam int IW       = $clog2(LANE_LEN);

    state_e state_q, state_d;
    logic   tick;
    logic   done_d, miss_d;

    logic              head_found, head_red, head_blue, del_hit, last_accept;
    logic [IW-1:0]     head_idx;
    logic [2:0]        offset_d;
    logic [LANE_LEN-1:0] del_mask, kept_r, kept_b, lane_r_d, lane_b_d;
    logic              in_r, in_b;

    step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_step_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q != IDLE),
        .tick   (tick)
    );

    // Head = highest occupied cell inside the judge window; ascending scan so the last hit wins.
    always_comb begin
        head_found = 1'b0;
        head_idx   = '0;
        for (int i = WIN_BASE; i < LANE_LEN; i++) begin
            if (lane_r[i] || lane_b[i]) begin
                head_found = 1'b1;
                head_idx   = IW'(i);
            end
        end
    end

    assign head_red  = head_found && lane_r[head_idx];
    assign head_blue = head_found && lane_b[head_idx];
    assign del_hit   = (delete_red_node && head_red) || (delete_blue_node && head_blue);
    assign offset_d  = head_found ? 3'(int'(head_idx) - WIN_BASE) : 3'd0;

    // A delete acts on the pre-shift lane, so a note deleted on a tick never reaches the exit.
    assign del_mask = del_hit ? (LANE_LEN'(1) << head_idx) : '0;
    assign kept_r   = lane_r & ~del_mask;
    assign kept_b   = lane_b & ~del_mask;

    assign chart_ready = tick && (state_q == RUN);
    assign in_r        = chart_ready && chart_valid && (chart_note == NOTE_RED);
    assign in_b        = chart_ready && chart_valid && (chart_note == NOTE_BLUE);
    assign last_accept = chart_ready && chart_valid && chart_last;

    assign lane_r_d = tick ? {kept_r[LANE_LEN-2:0], in_r} : kept_r;
    assign lane_b_d = tick ? {kept_b[LANE_LEN-2:0], in_b} : kept_b;
    assign miss_d   = tick && (kept_r[LANE_LEN-1] || kept_b[LANE_LEN-1]);

    // NOTE: every signal written here gets a default first, so no path can leave it
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_accept) state_d = DRAIN;
            DRAIN: begin
                if (tick && lane_r_d == '0 && lane_b_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lane_r  <= '0;
            lane_b  <= '0;
            node_R  <= 1'b0;
            node_B  <= 1'b0;
            offset  <= 3'd0;
            miss    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_r  <= lane_r_d;
            lane_b  <= lane_b_d;
            node_R  <= head_red;
            node_B  <= head_blue;
            offset  <= offset_d;
            miss    <= miss_d;
            done    <= done_d;
        end
    end

`ifdef NOTE_LANE_MISS_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_count <= 8'd0;
        end else if (state_q == IDLE && start) begin
            miss_count <= 8'd0;
        end else if (miss_d && miss_count != 8'hFF) begin
            miss_count <= miss_count + 8'd1;
        end
    end
`endif

endmodule
